// File: rtl/serializer_if.sv
// Parallel-load / serial-out handshake bundle.
// The producer side loads words; the serializer side streams bits.
interface serializer_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             serial_out;
   logic             serial_valid;
   logic             last;

   modport master (
      output load,
      output data_in,
      input  ready,
      input  serial_out,
      input  serial_valid,
      input  last
   );

   modport slave (
      input  load,
      input  data_in,
      output ready,
      output serial_out,
      output serial_valid,
      output last
   );
endinterface

// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter with back-to-back word chaining.
// A new word can be accepted during the final bit of the current one.
module serializer #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   serializer_if.slave bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_n;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic             cnt_zero;
   logic             rdy;
   logic             accept;

   assign cnt_zero = (cnt == '0);
   assign rdy      = (state == IDLE) || cnt_zero;
   assign accept   = bus.load && rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               shreg_n = bus.data_in;
               cnt_n   = CW'(WIDTH - 1);
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (!cnt_zero) begin
               shreg_n = {shreg[WIDTH-2:0], 1'b0};
               cnt_n   = cnt - CW'(1);
            end else if (accept) begin
               // final bit overlaps the next load: no idle gap
               shreg_n = bus.data_in;
               cnt_n   = CW'(WIDTH - 1);
            end else begin
               shreg_n = '0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
         end
      endcase
   end

   assign bus.ready        = rdy;
   assign bus.serial_valid = (state == SHIFT);
   assign bus.serial_out   = (state == SHIFT) && shreg[WIDTH-1];
   assign bus.last         = (state == SHIFT) && cnt_zero;

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 load  input  1  request to accept data_in as a new word.
REQ-005 data_in  input  WIDTH  parallel word to transmit.
REQ-006 ready  output  1  high when a word presented with load is accepted at the next rising edge.
REQ-007 serial_out  output  1  current transmitted bit, MSB first.
REQ-008 serial_valid  output  1  high when serial_out carries a valid data bit.
REQ-009 last  output  1  high during the final (LSB) bit of a word.

Function
REQ-010 The block SHALL implement two states: IDLE and SHIFT.
REQ-011 Accept event SHALL be load==1 and ready==1 at a rising edge with rst==0.
REQ-012 ready SHALL be 1 in IDLE and 1 in SHIFT when the bit counter equals 0; otherwise it SHALL be 0.
REQ-013 On accept, the block SHALL capture data_in into the shift register, set the bit counter to WIDTH-1, and enter SHIFT.
REQ-014 In SHIFT, serial_out SHALL equal shift register bit WIDTH-1, and serial_valid SHALL be 1.
REQ-015 In SHIFT, with counter>0, each edge SHALL shift the register left by one (zero fill) and decrement the counter.
REQ-016 last SHALL be 1 exactly when in SHIFT with counter==0.
REQ-017 In SHIFT with counter==0 and no accept, the next state SHALL be IDLE.
REQ-018 In SHIFT with counter==0 and accept, the new word SHALL load and SHIFT SHALL continue with no idle cycle (back-to-back).
REQ-019 load with ready==0 SHALL be ignored, with no effect on state, register, or counter.
REQ-020 In IDLE, serial_out, serial_valid, and last SHALL be 0.
REQ-021 Latency: a word accepted at edge N SHALL present its MSB in the cycle after edge N and its LSB (last=1) in the cycle after edge N+WIDTH-1.
REQ-022 Each accepted word SHALL produce exactly WIDTH consecutive serial_valid cycles.
REQ-023 data_in changes while not accepting SHALL have no effect on the word in flight.

Reset
REQ-024 rst==1 at an edge SHALL force IDLE, clear the shift register and counter to 0, and override any simultaneous load.
REQ-025 After reset: ready=1, serial_out=0, serial_valid=0, last=0.
REQ-026 Reset during SHIFT SHALL abort the word; no remaining bits SHALL be emitted.

Verification (WIDTH=8)
REQ-027 Reset, then accept 8'h55 -> serial_out 0,1,0,1,0,1,0,1 over 8 valid cycles; last and ready high only in the 8th; then IDLE outputs 0.
REQ-028 Accept 8'hAA, then hold load with 8'hFF during the last cycle -> 16 contiguous valid cycles: 1,0,1,0,1,0,1,0, then eight 1s; last high in cycles 8 and 16.
REQ-029 Accept 8'h0F, then pulse load with 8'hFF in cycles 2-7 -> ignored; output 0,0,0,0,1,1,1,1, then IDLE.
REQ-030 Assert rst in cycle 4 of word 8'hC3 -> next cycle serial_valid=0, serial_out=0, last=0, ready=1; no further bits.
REQ-031 rst=1 and load=1 with 8'hFF on the same edge -> block stays IDLE with outputs 0; the next accept of 8'h81 yields 1,0,0,0,0,0,0,1.
